// File: rtl/clock_set_controller.sv
// Set-time controller for the HH:MM clock: debounces the set switch and buttons,
// edits a shadow copy of the time and loads it back into the counter datapath.
module clock_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_set,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       run_en,
  output logic       load_en,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [2:0] blank_mask,
  output logic [1:0] state
);

  localparam int unsigned N_IN  = 4;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_EDIT_HR  = 2'd1,
    ST_EDIT_MIN = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  // Input bit order: 0 = sw_set, 1 = btn_mode, 2 = btn_up, 3 = btn_down
  logic [N_IN-1:0]  raw;
  logic [N_IN-1:0]  sync1_q, sync1_d;
  logic [N_IN-1:0]  sync2_q, sync2_d;
  logic [N_IN-1:0]  lvl_q, lvl_d;
  logic [N_IN-1:0]  lvl_prev_q, lvl_prev_d;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];
  logic [2:0]       press_q, press_d;

  state_t     state_q, state_d;
  logic [4:0] shadow_h_q, shadow_h_d;
  logic [5:0] shadow_m_q, shadow_m_d;
  logic       blink_q, blink_d;
  logic       run_en_q, run_en_d;
  logic       load_en_q, load_en_d;
  logic [2:0] blank_q, blank_d;

  logic sw_acc, ev_mode, ev_up, ev_down;

  assign raw     = {btn_down, btn_up, btn_mode, sw_set};
  assign sw_acc  = lvl_q[0];
  assign ev_mode = press_q[0];
  assign ev_up   = press_q[1];
  assign ev_down = press_q[2];

  // Wrapping hour step; simultaneous up/down cancel.
  function automatic logic [4:0] step_hr(input logic [4:0] h, input logic up, input logic dn);
    logic [4:0] r;
    r = h;
    if (up && !dn) r = (h >= HR_MAX) ? 5'd0 : h + 5'd1;
    else if (dn && !up) r = (h == 5'd0 || h > HR_MAX) ? HR_MAX : h - 5'd1;
    return r;
  endfunction

  // Wrapping minute step; simultaneous up/down cancel.
  function automatic logic [5:0] step_min(input logic [5:0] m, input logic up, input logic dn);
    logic [5:0] r;
    r = m;
    if (up && !dn) r = (m >= MIN_MAX) ? 6'd0 : m + 6'd1;
    else if (dn && !up) r = (m == 6'd0 || m > MIN_MAX) ? MIN_MAX : m - 6'd1;
    return r;
  endfunction

  // Synchronize, debounce and edge-detect the four raw inputs.
  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    lvl_d      = lvl_q;
    lvl_prev_d = lvl_q;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_LAST) lvl_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    press_d = lvl_q[3:1] & ~lvl_prev_q[3:1];
  end

  // Edit FSM; outputs are derived from the next state so they register alongside it.
  always_comb begin
    state_d    = state_q;
    shadow_h_d = shadow_h_q;
    shadow_m_d = shadow_m_q;
    blink_d    = tick_1hz ? ~blink_q : blink_q;

    case (state_q)
      ST_RUN: begin
        if (sw_acc) begin
          shadow_h_d = (cur_hours > HR_MAX) ? 5'd0 : cur_hours;
          shadow_m_d = (cur_minutes > MIN_MAX) ? 6'd0 : cur_minutes;
          state_d    = ST_EDIT_HR;
        end
      end
      ST_EDIT_HR: begin
        if (!sw_acc) begin
          state_d = ST_COMMIT;
        end else begin
          shadow_h_d = step_hr(shadow_h_q, ev_up, ev_down);
          if (ev_mode) state_d = ST_EDIT_MIN;
        end
      end
      ST_EDIT_MIN: begin
        if (!sw_acc) begin
          state_d = ST_COMMIT;
        end else begin
          shadow_m_d = step_min(shadow_m_q, ev_up, ev_down);
          if (ev_mode) state_d = ST_EDIT_HR;
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    // Blink restarts in the visible phase whenever a field is newly selected.
    if ((state_d == ST_EDIT_HR || state_d == ST_EDIT_MIN) && state_d != state_q)
      blink_d = 1'b0;

    run_en_d  = (state_d == ST_RUN);
    load_en_d = (state_d == ST_COMMIT);
    case (state_d)
      ST_EDIT_HR:  blank_d = {blink_d, 1'b0, 1'b1};
      ST_EDIT_MIN: blank_d = {1'b0, blink_d, 1'b1};
      default:     blank_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
      press_q    <= '0;
      state_q    <= ST_RUN;
      shadow_h_q <= '0;
      shadow_m_q <= '0;
      blink_q    <= 1'b0;
      run_en_q   <= 1'b1;
      load_en_q  <= 1'b0;
      blank_q    <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
      press_q    <= press_d;
      state_q    <= state_d;
      shadow_h_q <= shadow_h_d;
      shadow_m_q <= shadow_m_d;
      blink_q    <= blink_d;
      run_en_q   <= run_en_d;
      load_en_q  <= load_en_d;
      blank_q    <= blank_d;
    end
  end

  assign run_en       = run_en_q;
  assign load_en      = load_en_q;
  assign load_hours   = shadow_h_q;
  assign load_minutes = shadow_m_q;
  assign blank_mask   = blank_q;
  assign state        = state_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller; committed loads are checked against a
// queue of expected values pushed when each edit is closed.
module tb_clock_set_controller;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sw_set = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [4:0] cur_hours = '0;
  logic [5:0] cur_minutes = '0;
  logic       run_en, load_en;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [2:0] blank_mask;
  logic [1:0] state;

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   loads = 0;
  int   run_viol = 0;

  clock_set_controller #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .sw_set(sw_set), .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_down(btn_down), .tick_1hz(tick_1hz), .cur_hours(cur_hours),
    .cur_minutes(cur_minutes), .run_en(run_en), .load_en(load_en),
    .load_hours(load_hours), .load_minutes(load_minutes), .blank_mask(blank_mask),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // idx: 0 mode, 1 up, 2 down
  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: btn_mode = v;
      1: btn_up   = v;
      default: btn_down = v;
    endcase
  endtask

  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    cyc(8);
    set_btn(idx, 1'b0);
    cyc(8);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
  endtask

  // Waits (bounded) for EDIT_HR after sw_set has been raised and checks the latency.
  task automatic wait_edit(input string tag);
    int k;
    k = 0;
    while (state !== 2'd1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, (k >= DEB + 2 && k <= DEB + 4) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic commit(input logic [4:0] h, input logic [5:0] m);
    exp_t e;
    e.h = h;
    e.m = m;
    exp_q.push_back(e);
    sw_set = 1'b0;
    cyc(12);
    check("state_after_commit", 32'(state), 32'd0);
    check("run_en_after_commit", 32'(run_en), 32'd1);
  endtask

  // Scoreboard consumer and run_en consistency monitor.
  always @(negedge clk) begin
    if (!reset && (run_en !== (state == 2'd0))) run_viol++;
    if (load_en === 1'b1) begin
      exp_t e;
      loads++;
      check("load_state", 32'(state), 32'd3);
      if (exp_q.size() == 0) begin
        check("unexpected_load", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("load_hours", 32'(load_hours), 32'(e.h));
        check("load_minutes", 32'(load_minutes), 32'(e.m));
      end
    end
  end

  initial begin
    cyc(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_run_en", 32'(run_en), 32'd1);
    check("rst_load_en", 32'(load_en), 32'd0);
    check("rst_blank", 32'(blank_mask), 32'd0);
    reset = 1'b0;
    cyc(2);
    check("rst_shadow_h", 32'(load_hours), 32'd0);
    check("rst_shadow_m", 32'(load_minutes), 32'd0);

    // 10:25 plus three hour increments
    cur_hours = 5'd10; cur_minutes = 6'd25;
    sw_set = 1'b1;
    wait_edit("sw_latency");
    check("a_capture_h", 32'(load_hours), 32'd10);
    check("a_capture_m", 32'(load_minutes), 32'd25);
    check("a_run_en", 32'(run_en), 32'd0);
    check("a_blank", 32'(blank_mask), 32'b001);
    repeat (3) press(1);
    check("a_hours", 32'(load_hours), 32'd13);
    commit(5'd13, 6'd25);
    pulse_tick();
    check("run_blank_tick", 32'(blank_mask), 32'd0);

    // 23:59, hour wraps up, minutes wrap down through zero
    cur_hours = 5'd23; cur_minutes = 6'd59;
    sw_set = 1'b1;
    cyc(10);
    check("b_state", 32'(state), 32'd1);
    press(1);
    check("b_hr_wrap", 32'(load_hours), 32'd0);
    press(0);
    check("b_edit_min", 32'(state), 32'd2);
    press(2);
    check("b_min_dec", 32'(load_minutes), 32'd58);
    repeat (58) press(2);
    check("b_min_zero", 32'(load_minutes), 32'd0);
    press(2);
    check("b_min_wrap", 32'(load_minutes), 32'd59);
    commit(5'd0, 6'd59);

    // 05:28: blinking, bounce rejection, cancelling and coincident buttons
    cur_hours = 5'd5; cur_minutes = 6'd28;
    sw_set = 1'b1;
    cyc(10);
    check("c_blank0", 32'(blank_mask), 32'b001);
    pulse_tick();
    check("c_blank1", 32'(blank_mask), 32'b101);
    pulse_tick();
    check("c_blank2", 32'(blank_mask), 32'b001);
    repeat (5) begin
      btn_up = 1'b1; cyc(3);
      btn_up = 1'b0; cyc(3);
    end
    cyc(8);
    check("c_bounce", 32'(load_hours), 32'd5);
    btn_up = 1'b1; cyc(20);
    btn_up = 1'b0; cyc(8);
    check("c_held_once", 32'(load_hours), 32'd6);
    press(0);
    check("c_min_state", 32'(state), 32'd2);
    check("c_min_blank", 32'(blank_mask), 32'b001);
    pulse_tick();
    check("c_min_blank_t", 32'(blank_mask), 32'b011);
    press(1);
    press(1);
    check("c_min30", 32'(load_minutes), 32'd30);
    btn_up = 1'b1; btn_down = 1'b1; cyc(8);
    btn_up = 1'b0; btn_down = 1'b0; cyc(8);
    check("c_updown", 32'(load_minutes), 32'd30);
    btn_mode = 1'b1; btn_up = 1'b1; cyc(8);
    btn_mode = 1'b0; btn_up = 1'b0; cyc(8);
    check("c_mode_up_min", 32'(load_minutes), 32'd31);
    check("c_mode_up_state", 32'(state), 32'd1);
    commit(5'd6, 6'd31);

    // 07:45: reset in EDIT_MIN discards the edit; held switch re-enters edit
    cur_hours = 5'd7; cur_minutes = 6'd45;
    sw_set = 1'b1;
    cyc(10);
    press(0);
    check("d_state", 32'(state), 32'd2);
    check("d_min", 32'(load_minutes), 32'd45);
    reset = 1'b1;
    @(negedge clk);
    check("d_rst_state", 32'(state), 32'd0);
    check("d_rst_run_en", 32'(run_en), 32'd1);
    check("d_rst_load_en", 32'(load_en), 32'd0);
    check("d_rst_blank", 32'(blank_mask), 32'd0);
    check("d_rst_shadow", 32'(load_hours), 32'd0);
    cyc(2);
    reset = 1'b0;
    wait_edit("d_reentry_latency");
    check("d_recap_h", 32'(load_hours), 32'd7);
    check("d_recap_m", 32'(load_minutes), 32'd45);
    commit(5'd7, 6'd45);

    check("load_count", 32'(loads), 32'd4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("run_en_consistency", 32'(run_viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
